nn_config_loader: RTL and testbench

NN_CONFIG_LOADER -- requirements
Module: nn_config_loader

---
 rtl/nn_config_loader.sv | 229 ++++++++++++++++++++++
 tb/tb_nn_config_loader.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_config_loader.sv
// -----------------------------------------------------------------------------
// nn_config_loader
//
// Purpose:
//   Parses a 32-bit configuration stream into weight and bias write strobes
//   for one neuron at a time. Each sequence starts with a header word:
//     [31:30] type   00 = weights, 01 = bias, 11 = end, 10 = illegal
//     [29:22] layer number
//     [21:14] neuron number
//     [13:0]  payload word count (weights only)
//   Payload words are written out one cycle after they are accepted, through
//   registered strobes. An end header parks the block in DONE. A malformed
//   header parks it in ERROR. A start pulse returns it to IDLE from either.
//
// Ports:
//   clk                  rising-edge clock
//   reset                asynchronous active-low reset
//   cfgData / cfgValid   configuration stream word and its qualifier
//   cfgReady             loader accepts a word when cfgValid && cfgReady
//   start                one-cycle pulse, leaves DONE / ERROR
//   weightWriteEn        weight write strobe (weightValid is an alias)
//   weightAddr           weight index for the current strobe
//   weightData           weight word for the current strobe
//   biasWriteEn          bias write strobe
//   biasData             bias word for the current strobe
//   config_layer_number  latched layer field, zero-extended
//   config_neuron_number latched neuron field, zero-extended
//   busy, done, error    status flags
// -----------------------------------------------------------------------------
module nn_config_loader #(
   parameter int numWeights = 256,
   parameter int layerWidth = 8,
   parameter int neuronWidth = 8,
   localparam int addressWidth = $clog2(numWeights)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [31:0]             cfgData,
   input  logic                    cfgValid,
   output logic                    cfgReady,
   input  logic                    start,
   output logic                    weightWriteEn,
   output logic                    weightValid,
   output logic                    biasWriteEn,
   output logic [31:0]             weightData,
   output logic [31:0]             biasData,
   output logic [addressWidth-1:0] weightAddr,
   output logic [31:0]             config_layer_number,
   output logic [31:0]             config_neuron_number,
   output logic                    busy,
   output logic                    done,
   output logic                    error
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WEIGHT = 3'd1,
      BIAS   = 3'd2,
      DONE   = 3'd3,
      ERROR  = 3'd4
   } stateType;

   localparam logic [1:0]  typeWeights = 2'b00;
   localparam logic [1:0]  typeBias    = 2'b01;
   localparam logic [1:0]  typeEnd     = 2'b11;
   localparam logic [14:0] maxCount    = 15'(numWeights);

   stateType stateReg;
   stateType stateNext;

   // Header field decode, only meaningful while the FSM is in IDLE.
   logic [1:0]             hdrType;
   logic [layerWidth-1:0]  hdrLayer;
   logic [neuronWidth-1:0] hdrNeuron;
   logic [13:0]            hdrCount;
   logic                   countOk;

   assign hdrType   = cfgData[31:30];
   assign hdrLayer  = cfgData[22 +: layerWidth];
   assign hdrNeuron = cfgData[14 +: neuronWidth];
   assign hdrCount  = cfgData[13:0];
   assign countOk   = (hdrCount != 14'd0) && ({1'b0, hdrCount} <= maxCount);

   logic accept;
   assign accept = cfgValid && cfgReady;

   // Datapath registers
   logic                    weightWriteEnReg;
   logic                    biasWriteEnReg;
   logic [31:0]             weightDataReg;
   logic [31:0]             biasDataReg;
   logic [addressWidth-1:0] weightAddrReg;
   logic [addressWidth-1:0] wordCountReg;
   // Index of the final payload word (count - 1); saves a subtract per word.
   logic [addressWidth-1:0] lastIndexReg;
   logic [layerWidth-1:0]   layerReg;
   logic [neuronWidth-1:0]  neuronReg;

   logic lastWord;
   assign lastWord = (wordCountReg == lastIndexReg);

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stateReg <= IDLE;
      end else begin
         stateReg <= stateNext;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      stateNext = stateReg;
      case (stateReg)
         IDLE: begin
            if (cfgValid) begin
               case (hdrType)
                  typeWeights: stateNext = countOk ? WEIGHT : ERROR;
                  typeBias:    stateNext = BIAS;
                  typeEnd:     stateNext = DONE;
                  default:     stateNext = ERROR;
               endcase
            end
         end
         WEIGHT: begin
            if (cfgValid && lastWord) begin
               stateNext = IDLE;
            end
         end
         BIAS: begin
            if (cfgValid) begin
               stateNext = IDLE;
            end
         end
         DONE, ERROR: begin
            if (start) begin
               stateNext = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // FSM: state-decoded outputs
   // ---------------------------------------------------------------------
   always_comb begin
      cfgReady = 1'b0;
      busy     = weightWriteEnReg || biasWriteEnReg;
      done     = 1'b0;
      error    = 1'b0;
      case (stateReg)
         IDLE:   cfgReady = 1'b1;
         WEIGHT: begin
            cfgReady = 1'b1;
            busy     = 1'b1;
         end
         BIAS: begin
            cfgReady = 1'b1;
            busy     = 1'b1;
         end
         DONE:   done  = 1'b1;
         ERROR:  error = 1'b1;
         default: cfgReady = 1'b0;
      endcase
   end

   // ---------------------------------------------------------------------
   // Datapath: header latching, word counter and registered strobes.
   // Strobes default low every cycle so each accepted word yields exactly
   // one strobe cycle; data and address hold between strobes.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         weightWriteEnReg <= 1'b0;
         biasWriteEnReg   <= 1'b0;
         weightDataReg    <= '0;
         biasDataReg      <= '0;
         weightAddrReg    <= '0;
         wordCountReg     <= '0;
         lastIndexReg     <= '0;
         layerReg         <= '0;
         neuronReg        <= '0;
      end else begin
         weightWriteEnReg <= 1'b0;
         biasWriteEnReg   <= 1'b0;
         if (accept) begin
            case (stateReg)
               IDLE: begin
                  if (hdrType == typeWeights && countOk) begin
                     layerReg     <= hdrLayer;
                     neuronReg    <= hdrNeuron;
                     lastIndexReg <= addressWidth'(hdrCount - 14'd1);
                     wordCountReg <= '0;
                  end else if (hdrType == typeBias) begin
                     layerReg  <= hdrLayer;
                     neuronReg <= hdrNeuron;
                  end
               end
               WEIGHT: begin
                  weightWriteEnReg <= 1'b1;
                  weightDataReg    <= cfgData;
                  weightAddrReg    <= wordCountReg;
                  wordCountReg     <= wordCountReg + 1'b1;
               end
               BIAS: begin
                  biasWriteEnReg <= 1'b1;
                  biasDataReg    <= cfgData;
               end
               default: ;
            endcase
         end
      end
   end

   assign weightWriteEn        = weightWriteEnReg;
   assign weightValid          = weightWriteEnReg;
   assign biasWriteEn          = biasWriteEnReg;
   assign weightData           = weightDataReg;
   assign biasData             = biasDataReg;
   assign weightAddr           = weightAddrReg;
   assign config_layer_number  = 32'(layerReg);
   assign config_neuron_number = 32'(neuronReg);

endmodule

// File: tb/tb_nn_config_loader.sv
// -----------------------------------------------------------------------------
// tb_nn_config_loader
//
// Purpose:
//   Directed stimulus for nn_config_loader. Each payload word sent pushes the
//   expected strobe into a queue; a negedge monitor pops and compares every
//   strobe the DUT raises. Status flags are compared directly in the stimulus.
// -----------------------------------------------------------------------------
module tb_nn_config_loader;

   logic        clk;
   logic        reset;
   logic [31:0] cfgData;
   logic        cfgValid;
   logic        cfgReady;
   logic        start;
   logic        weightWriteEn;
   logic        weightValid;
   logic        biasWriteEn;
   logic [31:0] weightData;
   logic [31:0] biasData;
   logic [7:0]  weightAddr;
   logic [31:0] config_layer_number;
   logic [31:0] config_neuron_number;
   logic        busy;
   logic        done;
   logic        error;

   nn_config_loader #(
      .numWeights (256),
      .layerWidth (8),
      .neuronWidth(8)
   ) dut (
      .clk                 (clk),
      .reset               (reset),
      .cfgData             (cfgData),
      .cfgValid            (cfgValid),
      .cfgReady            (cfgReady),
      .start               (start),
      .weightWriteEn       (weightWriteEn),
      .weightValid         (weightValid),
      .biasWriteEn         (biasWriteEn),
      .weightData          (weightData),
      .biasData            (biasData),
      .weightAddr          (weightAddr),
      .config_layer_number (config_layer_number),
      .config_neuron_number(config_neuron_number),
      .busy                (busy),
      .done                (done),
      .error               (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          isBias;
      logic [7:0]  addr;
      logic [31:0] data;
      logic [31:0] layer;
      logic [31:0] neuron;
   } expType;

   expType expQ[$];
   int testsRun    = 0;
   int testsFailed = 0;

   // ---------------------------------------------------------------------
   // Scoreboard monitor
   // ---------------------------------------------------------------------
   expType monExp;
   bit     monBad;

   always @(negedge clk) begin
      if (reset && (weightWriteEn || biasWriteEn)) begin
         testsRun++;
         if (expQ.size() == 0) begin
            testsFailed++;
            $display("[TB] FAIL unexpected_strobe: got wEn=%0b bEn=%0b addr=%0d wData=%h bData=%h, required no strobe",
                     weightWriteEn, biasWriteEn, weightAddr, weightData, biasData);
         end else begin
            monExp = expQ.pop_front();
            monBad = (weightWriteEn && biasWriteEn) || (weightValid != weightWriteEn)
                     || (config_layer_number != monExp.layer)
                     || (config_neuron_number != monExp.neuron);
            if (monExp.isBias)
               monBad = monBad || !biasWriteEn || (biasData != monExp.data);
            else
               monBad = monBad || !weightWriteEn || (weightAddr != monExp.addr)
                        || (weightData != monExp.data);
            if (monBad) begin
               testsFailed++;
               $display("[TB] FAIL strobe: got wEn=%0b wValid=%0b bEn=%0b addr=%0d wData=%h bData=%h layer=%0d neuron=%0d, required %s addr=%0d data=%h layer=%0d neuron=%0d",
                        weightWriteEn, weightValid, biasWriteEn, weightAddr, weightData, biasData,
                        config_layer_number, config_neuron_number,
                        monExp.isBias ? "bias" : "weight", monExp.addr, monExp.data,
                        monExp.layer, monExp.neuron);
            end else begin
               $display("[TB] %s addr=%0d data=%h layer=%0d neuron=%0d ok",
                        monExp.isBias ? "bias  " : "weight", monExp.addr, monExp.data,
                        monExp.layer, monExp.neuron);
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Helpers
   // ---------------------------------------------------------------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic pushW(input int addr, input logic [31:0] data, input int layer, input int neuron);
      expType e;
      e.isBias = 1'b0;
      e.addr   = 8'(addr);
      e.data   = data;
      e.layer  = 32'(layer);
      e.neuron = 32'(neuron);
      expQ.push_back(e);
   endtask

   task automatic pushB(input logic [31:0] data, input int layer, input int neuron);
      expType e;
      e.isBias = 1'b1;
      e.addr   = 8'd0;
      e.data   = data;
      e.layer  = 32'(layer);
      e.neuron = 32'(neuron);
      expQ.push_back(e);
   endtask

   // Presents a word for one clock edge; cfgValid stays high on return.
   task automatic sendWord(input logic [31:0] w);
      cfgData  = w;
      cfgValid = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      cfgValid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulseStart();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // ---------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------
   logic [31:0] wordsA[4];
   logic [31:0] badHdr[3];

   initial begin
      wordsA = '{32'hA000_0001, 32'hB000_0002, 32'hC000_0003, 32'hD000_0004};
      badHdr = '{32'h0040_4000, 32'h0040_4101, 32'h8000_0000};
      reset    = 1'b0;
      cfgData  = '0;
      cfgValid = 1'b0;
      start    = 1'b0;

      // Reset state
      #2;
      check("rst_cfgReady", 32'(cfgReady), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      check("rst_wEn", 32'(weightWriteEn), 32'd0);
      check("rst_bEn", 32'(biasWriteEn), 32'd0);
      check("rst_layer", config_layer_number, 32'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;

      // Four weights, continuous valid, then a bias header back to back
      sendWord(32'h0040_4004);
      check("hdr_busy", 32'(busy), 32'd1);
      check("hdr_cfgReady", 32'(cfgReady), 32'd1);
      for (int i = 0; i < 4; i++) begin
         pushW(i, wordsA[i], 1, 1);
         sendWord(wordsA[i]);
      end
      check("last_strobe_busy", 32'(busy), 32'd1);
      check("last_strobe_cfgReady", 32'(cfgReady), 32'd1);
      sendWord(32'h4081_4000);
      pushB(32'h0000_007F, 2, 5);
      sendWord(32'h0000_007F);
      idle(2);
      check("bias_idle_busy", 32'(busy), 32'd0);
      check("bias_hold_layer", config_layer_number, 32'd2);
      check("bias_hold_neuron", config_neuron_number, 32'd5);

      // Three weights with a two-cycle gap between words 1 and 2
      sendWord(32'h00C1_C003);
      pushW(0, 32'h1111_0000, 3, 7);
      sendWord(32'h1111_0000);
      pushW(1, 32'h1111_0001, 3, 7);
      sendWord(32'h1111_0001);
      idle(2);
      check("gap_busy", 32'(busy), 32'd1);
      pushW(2, 32'h1111_0002, 3, 7);
      sendWord(32'h1111_0002);
      idle(2);
      check("gap_done_busy", 32'(busy), 32'd0);

      // start while in WEIGHT is ignored
      sendWord(32'h0140_4001);
      cfgValid = 1'b0;
      pulseStart();
      check("start_in_weight_busy", 32'(busy), 32'd1);
      check("start_in_weight_done", 32'(done), 32'd0);
      pushW(0, 32'hCAFE_0001, 5, 1);
      sendWord(32'hCAFE_0001);
      idle(2);

      // Boundary: count equal to numWeights
      sendWord(32'h0040_4100);
      for (int i = 0; i < 256; i++) begin
         pushW(i, 32'hB000_0000 | 32'(i), 1, 1);
         sendWord(32'hB000_0000 | 32'(i));
      end
      idle(2);
      check("max_count_busy", 32'(busy), 32'd0);
      check("max_count_error", 32'(error), 32'd0);

      // Illegal headers: count 0, count numWeights+1, type 10
      for (int h = 0; h < 3; h++) begin
         sendWord(badHdr[h]);
         check($sformatf("err%0d_error", h), 32'(error), 32'd1);
         check($sformatf("err%0d_cfgReady", h), 32'(cfgReady), 32'd0);
         check($sformatf("err%0d_busy", h), 32'(busy), 32'd0);
         @(posedge clk); #1;
         check($sformatf("err%0d_sticky", h), 32'(error), 32'd1);
         cfgValid = 1'b0;
         pulseStart();
         check($sformatf("err%0d_cleared", h), 32'(error), 32'd0);
         check($sformatf("err%0d_ready_again", h), 32'(cfgReady), 32'd1);
      end

      // End header; words offered in DONE are refused, including on start
      sendWord(32'hC000_0000);
      check("end_done", 32'(done), 32'd1);
      check("end_cfgReady", 32'(cfgReady), 32'd0);
      cfgData = 32'h0040_4004;
      repeat (3) @(posedge clk);
      #1;
      check("end_done_held", 32'(done), 32'd1);
      start = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      cfgValid = 1'b0;
      check("end_start_done", 32'(done), 32'd0);
      check("end_start_cfgReady", 32'(cfgReady), 32'd1);
      check("end_start_word_ignored", 32'(busy), 32'd0);

      // Reset after two of four weight words
      sendWord(32'h0101_0004);
      pushW(0, 32'h2222_0000, 4, 4);
      sendWord(32'h2222_0000);
      pushW(1, 32'h2222_0001, 4, 4);
      sendWord(32'h2222_0001);
      idle(1);
      reset = 1'b0;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_layer", config_layer_number, 32'd0);
      check("midrst_addr", 32'(weightAddr), 32'd0);
      check("midrst_cfgReady", 32'(cfgReady), 32'd1);
      @(posedge clk); #1;
      reset = 1'b1;
      idle(2);
      sendWord(32'h40C1_8000);
      pushB(32'h1234_5678, 3, 6);
      sendWord(32'h1234_5678);
      idle(3);
      check("post_rst_busy", 32'(busy), 32'd0);
      check("post_rst_layer", config_layer_number, 32'd3);

      check("scoreboard_drained", 32'(expQ.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
